// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Purpose:
//   Two requesters share a single add/subtract datapath. An arbiter picks one
//   request while the FSM is IDLE. Operands are captured, the result is
//   computed in EXEC, and the result is held in HOLD until the consumer takes
//   it. Each operation therefore occupies the unit for at least three cycles.
//
// Configuration macro:
//   ADDSUB_ARB_ROUND_ROBIN_EN  defined   -> on contention, grant the requester
//                                            that was not granted last.
//                              undefined -> fixed priority, requester 0 wins.
//
// Handshake semantics (both request ports and the result port):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid and its payload stable until that edge. reqN_ready
//   depends combinationally on reqN_valid and is only ever high in IDLE.
//   res_valid is high only in HOLD, and res_* stay stable while it is high.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   reqN_valid   in   requester N has an operation (N = 0, 1)
//   reqN_ready   out  requester N is accepted this cycle
//   reqN_a/b     in   WIDTH-bit operands
//   reqN_sub     in   1 = a - b, 0 = a + b
//   res_valid    out  result available
//   res_ready    in   consumer takes the result
//   res_data     out  WIDTH-bit sum/difference (wraps modulo 2^WIDTH)
//   res_carry    out  carry-out; for subtract 1 means no borrow
//   res_ovf      out  signed two's-complement overflow
//   res_id       out  index of the requester that issued the operation
//   dbg_state_o  out  FSM state (0 = IDLE, 1 = EXEC, 2 = HOLD)
// -----------------------------------------------------------------------------
module addsub_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_id,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Captured operation
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             id_q, id_d;

    // Registered result
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_id_q, res_id_d;

    // Arbitration result, independent of FSM state
    logic gnt0, gnt1;
    logic accept0, accept1;

    // Shared datapath
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   sum_w;
    logic             ovf_w;

`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
    // prio_q = 0 favours requester 0, prio_q = 1 favours requester 1.
    logic prio_q, prio_d;

    always_comb begin
        gnt0 = req0_valid && (!req1_valid || !prio_q);
        gnt1 = req1_valid && (!req0_valid ||  prio_q);
    end

    // After granting requester 0 the pointer favours requester 1 and vice versa.
    always_comb begin
        prio_d = prio_q;
        if (accept0) begin
            prio_d = 1'b1;
        end else if (accept1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid && !req0_valid;
    end
`endif

    // Ready is gated with rst_n so it drops the instant reset is asserted,
    // even though valid inputs may still be high.
    always_comb begin
        accept0 = rst_n && (state_q == IDLE) && gnt0;
        accept1 = rst_n && (state_q == IDLE) && gnt1;
    end

    assign req0_ready = accept0;
    assign req1_ready = accept1;

    // Subtract is a + ~b + 1: invert b and feed sub as the carry-in.
    always_comb begin
        b_inv = b_q ^ {WIDTH{sub_q}};
        sum_w = {1'b0, a_q} + {1'b0, b_inv} + {{WIDTH{1'b0}}, sub_q};
        ovf_w = (a_q[WIDTH-1] == b_inv[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Next-state and register update logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;

        case (state_q)
            IDLE: begin
                if (accept0) begin
                    a_d     = req0_a;
                    b_d     = req0_b;
                    sub_d   = req0_sub;
                    id_d    = 1'b0;
                    state_d = EXEC;
                end else if (accept1) begin
                    a_d     = req1_a;
                    b_d     = req1_b;
                    sub_d   = req1_sub;
                    id_d    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = sum_w[WIDTH-1:0];
                res_carry_d = sum_w[WIDTH];
                res_ovf_d   = ovf_w;
                res_id_d    = id_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid   = (state_q == HOLD);
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign res_ovf     = res_ovf_q;
    assign res_id      = res_id_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_carry, res_ovf, res_id;
  logic [1:0]   dbg_state;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int passes = 0;

  // Expected result items: {id, ovf, carry, data}
  logic [W+2:0] exp_q[$];

  // Reference model written from the arithmetic definition, not the datapath.
  function automatic logic [W+2:0] model(input bit id, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input bit sub);
    logic [W:0]   wide;
    logic [W-1:0] d;
    logic         c, o;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b};
      d = wide[W-1:0];
      c = wide[W];
      o = (a[W-1] == b[W-1]) && (d[W-1] != a[W-1]);
    end else begin
      d = a - b;
      c = (a >= b);
      o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    end
    return {id, o, c, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W+2:0] got_v;
    logic [W+2:0] exp_v;
    if (rst_n && (req0_ready || req1_ready)) begin
      checks++;
      if (req0_ready && req1_ready)
        $display("FAIL excl_ready: req0_ready=1 req1_ready=1, required at most one");
      else
        passes++;
    end
    if (rst_n && res_valid && res_ready) begin
      got_v = {res_id, res_ovf, res_carry, res_data};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL result_unexpected: got %h, required no result", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v)
          $display("FAIL result {id,ovf,carry,data}: got %h, required %h", got_v, exp_v);
        else
          passes++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit id, input bit v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit sub);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  // Present a request, wait for its grant, push the expected result.
  // waits = number of cycles spent waiting before the granted cycle.
  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sub, output int waits);
    bit got;
    got = 0;
    waits = -1;
    drive(id, 1'b1, a, b, sub);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        exp_q.push_back(model(id, a, b, sub));
        got = 1;
        waits = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(id, 1'b0, a, b, sub);
    checks++;
    if (!got) $display("FAIL grant_timeout req%0d: got no ready, required ready within 40 cycles", id);
    else passes++;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !res_valid) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) $display("FAIL drain_timeout: pending=%0d res_valid=%b, required 0 and 0", exp_q.size(), res_valid);
    else passes++;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    drive(0, 1'b1, 32'h1, 32'h2, 1'b0);
    drive(1, 1'b1, 32'h3, 32'h4, 1'b1);
    #1;
    checks += 8;
    if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b, required 0", res_valid); else passes++;
    if (res_data !== 32'h0) $display("FAIL reset_res_data: got %h, required 0", res_data); else passes++;
    if (res_carry !== 1'b0) $display("FAIL reset_res_carry: got %b, required 0", res_carry); else passes++;
    if (res_ovf !== 1'b0) $display("FAIL reset_res_ovf: got %b, required 0", res_ovf); else passes++;
    if (res_id !== 1'b0) $display("FAIL reset_res_id: got %b, required 0", res_id); else passes++;
    if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b, required 0", req0_ready); else passes++;
    if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b, required 0", req1_ready); else passes++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d, required 0", dbg_state); else passes++;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    int w;
    res_ready = 1'b1;
    send(0, 32'h0000_0005, 32'h0000_0003, 1'b0, w);
    // Now in the cycle after capture: the result must not be valid yet.
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) $display("FAIL add_latency_early: res_valid got %b, required 0", res_valid); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 5;
    if (res_valid !== 1'b1) $display("FAIL add_latency: res_valid got %b, required 1", res_valid); else passes++;
    if (res_data !== 32'h0000_0008) $display("FAIL add_data: got %h, required 00000008", res_data); else passes++;
    if (res_carry !== 1'b0) $display("FAIL add_carry: got %b, required 0", res_carry); else passes++;
    if (res_ovf !== 1'b0) $display("FAIL add_ovf: got %b, required 0", res_ovf); else passes++;
    if (res_id !== 1'b0) $display("FAIL add_id: got %b, required 0", res_id); else passes++;
    wait_drain();
  endtask

  task automatic test_subtract();
    int w;
    res_ready = 1'b1;
    send(1, 32'h8000_0000, 32'h0000_0001, 1'b1, w);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks += 4;
    if (res_data !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_data: got %h, required 7fffffff", res_data); else passes++;
    if (res_carry !== 1'b1) $display("FAIL sub_ovf_carry: got %b, required 1", res_carry); else passes++;
    if (res_ovf !== 1'b1) $display("FAIL sub_ovf_ovf: got %b, required 1", res_ovf); else passes++;
    if (res_id !== 1'b1) $display("FAIL sub_ovf_id: got %b, required 1", res_id); else passes++;
    wait_drain();
    send(1, 32'h0000_0000, 32'h0000_0001, 1'b1, w);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (res_data !== 32'hFFFF_FFFF) $display("FAIL sub_borrow_data: got %h, required ffffffff", res_data); else passes++;
    if (res_carry !== 1'b0) $display("FAIL sub_borrow_carry: got %b, required 0", res_carry); else passes++;
    if (res_ovf !== 1'b0) $display("FAIL sub_borrow_ovf: got %b, required 0", res_ovf); else passes++;
    wait_drain();
  endtask

  task automatic test_contention();
    logic [W-1:0] a0, b0, a1, b1;
    bit s0, s1, up0, up1;
    int g[4];
    int exp_g[4];
    int ng;
`ifdef ADDSUB_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    g = '{-1, -1, -1, -1};
    ng = 0;
    res_ready = 1'b1;
    a0 = $urandom; b0 = $urandom; s0 = $urandom_range(0, 1);
    a1 = $urandom; b1 = $urandom; s1 = $urandom_range(0, 1);
    drive(0, 1'b1, a0, b0, s0);
    drive(1, 1'b1, a1, b1, s1);
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clk);
      up0 = 0;
      up1 = 0;
      if (req0_ready) begin
        exp_q.push_back(model(0, a0, b0, s0));
        if (ng < 4) g[ng] = 0;
        ng++;
        up0 = 1;
      end
      if (req1_ready) begin
        exp_q.push_back(model(1, a1, b1, s1));
        if (ng < 4) g[ng] = 1;
        ng++;
        up1 = 1;
      end
      @(posedge clk); #1;
      if (up0) begin
        a0 = $urandom; b0 = $urandom; s0 = $urandom_range(0, 1);
        drive(0, 1'b1, a0, b0, s0);
      end
      if (up1) begin
        a1 = $urandom; b1 = $urandom; s1 = $urandom_range(0, 1);
        drive(1, 1'b1, a1, b1, s1);
      end
    end
    drive(0, 1'b0, a0, b0, s0);
    drive(1, 1'b0, a1, b1, s1);
    checks++;
    if (ng != 4) $display("FAIL contention_grants: got %0d grants, required 4", ng); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g[i] != exp_g[i]) $display("FAIL contention_order[%0d]: got %0d, required %0d", i, g[i], exp_g[i]);
      else passes++;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    logic [W-1:0] a0, b0;
    logic [W+2:0] got_v;
    a0 = $urandom;
    b0 = $urandom;
    res_ready = 1'b0;
    send(0, a0, b0, 1'b1, w);
    // Competing request waits while the result is held.
    drive(1, 1'b1, 32'h0000_1234, 32'h0000_0034, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got_v = {res_id, res_ovf, res_carry, res_data};
      checks += 3;
      if (res_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b, required 1", i, res_valid); else passes++;
      if (got_v !== exp_q[0]) $display("FAIL bp_stable[%0d]: got %h, required %h", i, got_v, exp_q[0]); else passes++;
      if (req1_ready !== 1'b0) $display("FAIL bp_no_grant[%0d]: req1_ready got %b, required 0", i, req1_ready); else passes++;
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    // Result is taken at the next edge, so the waiting request is granted one cycle later.
    send(1, 32'h0000_1234, 32'h0000_0034, 1'b1, w);
    checks++;
    if (w != 1) $display("FAIL bp_release: grant after %0d cycles, required 1", w); else passes++;
    wait_drain();
  endtask

  task automatic test_reset_mid_op();
    int w;
    res_ready = 1'b1;
    send(1, 32'h0000_4321, 32'h0000_1111, 1'b0, w);
    // Now in EXEC; req0 starts waiting and reset hits mid-cycle.
    drive(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks += 7;
    if (res_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", res_valid); else passes++;
    if (res_data !== 32'h0) $display("FAIL midrst_data: got %h, required 0", res_data); else passes++;
    if (res_carry !== 1'b0) $display("FAIL midrst_carry: got %b, required 0", res_carry); else passes++;
    if (res_ovf !== 1'b0) $display("FAIL midrst_ovf: got %b, required 0", res_ovf); else passes++;
    if (res_id !== 1'b0) $display("FAIL midrst_id: got %b, required 0", res_id); else passes++;
    if (req0_ready !== 1'b0) $display("FAIL midrst_ready: got %b, required 0", req0_ready); else passes++;
    if (dbg_state !== 2'd0) $display("FAIL midrst_state: got %0d, required 0", dbg_state); else passes++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
    checks++;
    if (w != 0) $display("FAIL midrst_first_arb: grant after %0d cycles, required 0", w); else passes++;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks += 4;
    if (res_data !== 32'h0) $display("FAIL midrst_wrap_data: got %h, required 0", res_data); else passes++;
    if (res_carry !== 1'b1) $display("FAIL midrst_wrap_carry: got %b, required 1", res_carry); else passes++;
    if (res_ovf !== 1'b0) $display("FAIL midrst_wrap_ovf: got %b, required 0", res_ovf); else passes++;
    if (res_id !== 1'b0) $display("FAIL midrst_wrap_id: got %b, required 0", res_id); else passes++;
    wait_drain();
  endtask

  task automatic test_random();
    int w;
    logic [W-1:0] a, b;
    bit id, sub;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      id = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 3); end
        1: begin a = 32'h8000_0000; b = $urandom_range(0, 3); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      send(id, a, b, sub, w);
      wait_drain();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_results: got %0d pending, required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
